hist_readout: RTL and testbench

- Reader-side companion to the 8-bin image histogram accumulator; walks every bin through the accumulator's registered read port (address in, count out one clock later).
- Streams each bin downstream over a valid/ready handshake, with a running cumulative sum (CDF) for histogram equalization.
- Reports the peak bin at the end of each pass.
- Drives a gate signal that freezes accumulation while a readout pass is in progress.

---
 rtl/hist_readout.sv | 116 +++++++++++
 tb/tb_hist_readout.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hist_readout.sv
// Walks the histogram accumulator bins via its registered read port and streams count + running CDF.
// Each bin takes ISSUE/WAIT/OUT (3 cycles min); the beat holds stable under out_ready backpressure.
module hist_readout #(
  parameter int NBINS = 8,
  parameter int CW    = 14,
  parameter int AW    = 6,
  parameter int SW    = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] hist_addr,
  input  logic [CW-1:0] hist_data,
  output logic          acc_en_gate,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2:0]    out_bin,
  output logic [CW-1:0] out_count,
  output logic [SW-1:0] out_cum,
  output logic          busy,
  output logic          done,
  output logic [2:0]    max_bin,
  output logic [CW-1:0] max_count
);

  localparam int IW = $clog2(NBINS);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] OUT   = 3'd3;
  localparam logic [2:0] FIN   = 3'd4;

  logic [2:0]    state;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_next;
  logic [SW-1:0] cum;
  logic [SW-1:0] cum_next;
  logic [CW-1:0] run_max;
  logic [IW-1:0] run_bin;

  assign idx_next = idx + 1'b1;
  assign cum_next = cum + SW'(hist_data);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      idx         <= '0;
      cum         <= '0;
      run_max     <= '0;
      run_bin     <= '0;
      hist_addr   <= '0;
      acc_en_gate <= 1'b1;
      out_valid   <= 1'b0;
      out_bin     <= '0;
      out_count   <= '0;
      out_cum     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      max_bin     <= '0;
      max_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= ISSUE;
            idx         <= '0;
            cum         <= '0;
            run_max     <= '0;
            run_bin     <= '0;
            hist_addr   <= '0;
            busy        <= 1'b1;
            acc_en_gate <= 1'b0;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          out_count <= hist_data;
          out_bin   <= 3'(idx);
          out_cum   <= cum_next;
          cum       <= cum_next;
          out_valid <= 1'b1;
          // Strict compare: on a tie the earlier (lower) bin keeps the peak.
          if (hist_data > run_max) begin
            run_max <= hist_data;
            run_bin <= idx;
          end
          state <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (idx == IW'(NBINS - 1)) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              idx       <= idx_next;
              hist_addr <= AW'(idx_next);
              state     <= ISSUE;
            end
          end
        end
        FIN: begin
          max_bin     <= 3'(run_bin);
          max_count   <= run_max;
          done        <= 1'b0;
          busy        <= 1'b0;
          acc_en_gate <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hist_readout.sv
// Bench for hist_readout: table-driven passes, randomized histograms and ready, reset/start corner cases.
module tb_hist_readout;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  hist_addr;
  logic [13:0] hist_data;
  logic        acc_en_gate;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [2:0]  out_bin;
  logic [13:0] out_count;
  logic [16:0] out_cum;
  logic        busy;
  logic        done;
  logic [2:0]  max_bin;
  logic [13:0] max_count;

  hist_readout dut (
    .clk(clk), .rst(rst), .start(start), .hist_addr(hist_addr), .hist_data(hist_data),
    .acc_en_gate(acc_en_gate), .out_valid(out_valid), .out_ready(out_ready),
    .out_bin(out_bin), .out_count(out_count), .out_cum(out_cum), .busy(busy),
    .done(done), .max_bin(max_bin), .max_count(max_count)
  );

  always #5 clk = ~clk;

  // Accumulator stand-in: registered read, data one clock after the address.
  logic [7:0][13:0] hist;
  always @(posedge clk) hist_data <= hist[hist_addr[2:0]];

  typedef struct {
    int bin;
    int cnt;
    int cum;
  } beat_t;

  typedef struct {
    logic [7:0][13:0] b;
    int mode;
    bit poke;
    bit tcheck;
    int exp_cum;
    int exp_mb;
    int exp_mc;
  } vec_t;

  int    checks = 0;
  int    failures = 0;
  int    ready_mode = 0;
  int    stall = 0;
  bit    prev_stall = 0;
  beat_t held;
  beat_t q[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic logic [7:0][13:0] mk(input int a0, input int a1, input int a2, input int a3,
                                          input int a4, input int a5, input int a6, input int a7);
    logic [7:0][13:0] r;
    r[0] = 14'(a0); r[1] = 14'(a1); r[2] = 14'(a2); r[3] = 14'(a3);
    r[4] = 14'(a4); r[5] = 14'(a5); r[6] = 14'(a6); r[7] = 14'(a7);
    return r;
  endfunction

  // Downstream sink: picks ready for the coming edge, then logs beats that will be accepted on it.
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 0;
    end else begin
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 2) != 0);
        default: begin
          if (out_valid && out_bin == 3'd2 && stall < 4) begin
            out_ready = 1'b0;
            stall++;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
      if (out_valid) begin
        chk("gate_low_during_beat", acc_en_gate, 0);
        chk("busy_during_beat", busy, 1);
      end
      if (prev_stall) begin
        chk("stall_valid_held", out_valid, 1);
        chk("stall_bin_held", out_bin, held.bin);
        chk("stall_count_held", out_count, held.cnt);
        chk("stall_cum_held", out_cum, held.cum);
      end
      if (out_valid && out_ready) q.push_back('{int'(out_bin), int'(out_count), int'(out_cum)});
      prev_stall = out_valid && !out_ready;
      held = '{int'(out_bin), int'(out_count), int'(out_cum)};
    end
  end

  task automatic wait_done(output bit seen, output int cyc);
    seen = 0;
    cyc = 0;
    while (cyc < 2000 && !seen) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1;
    end
  endtask

  // One full pass, checked against prefix sums and a strict-greater peak search over the bins.
  task automatic run_pass(input logic [7:0][13:0] b, input int mode, input bit poke, input bit tcheck,
                          output int dut_cum, output int dut_mb, output int dut_mc);
    int cyc;
    bit seen;
    int cum;
    int mb;
    int mc;
    hist = b;
    ready_mode = mode;
    stall = 0;
    q.delete();
    @(negedge clk);
    start = 1'b1;
    seen = 0;
    cyc = 0;
    while (cyc < 2000 && !seen) begin
      @(negedge clk);
      cyc++;
      start = (poke && cyc == 10) ? 1'b1 : 1'b0;
      if (done) seen = 1;
    end
    start = 1'b0;
    chk("done_seen", seen, 1);
    if (tcheck) chk("done_latency", cyc, 25);
    chk("busy_in_done_cycle", busy, 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
    chk("gate_after_done", acc_en_gate, 1);
    chk("beat_total", q.size(), 8);
    cum = 0;
    mb = 0;
    mc = 0;
    for (int k = 0; k < 8; k++) begin
      cum += int'(b[k]);
      if (int'(b[k]) > mc) begin
        mc = int'(b[k]);
        mb = k;
      end
      if (k < q.size()) begin
        chk("beat_bin", q[k].bin, k);
        chk("beat_count", q[k].cnt, b[k]);
        chk("beat_cum", q[k].cum, cum);
      end
    end
    chk("model_max_bin", max_bin, mb);
    chk("model_max_count", max_count, mc);
    dut_cum = (q.size() > 0) ? q[q.size()-1].cum : -1;
    dut_mb = int'(max_bin);
    dut_mc = int'(max_count);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[5];
    int dc, dmb, dmc, cyc;
    bit seen, found;
    logic [7:0][13:0] r;

    tbl[0] = '{mk(10, 20, 30, 40, 50, 60, 70, 80), 0, 0, 1, 360, 7, 80};
    tbl[1] = '{mk(5, 900, 900, 3, 0, 0, 0, 1), 0, 0, 1, 1809, 1, 900};
    tbl[2] = '{mk(1, 2, 3, 4, 5, 6, 7, 8), 2, 0, 0, 36, 7, 8};
    tbl[3] = '{mk(16383, 16383, 16383, 16383, 16383, 16383, 16383, 16383), 1, 0, 0, 131064, 0, 16383};
    tbl[4] = '{mk(0, 0, 0, 0, 0, 0, 0, 0), 0, 1, 1, 0, 0, 0};
    hist = '0;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gate", acc_en_gate, 1);
    chk("rst_done", done, 0);
    chk("rst_max_bin", max_bin, 0);
    chk("rst_max_count", max_count, 0);
    chk("rst_out_cum", out_cum, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    for (int i = 0; i < 5; i++) begin
      run_pass(tbl[i].b, tbl[i].mode, tbl[i].poke, tbl[i].tcheck, dc, dmb, dmc);
      chk("tbl_final_cum", dc, tbl[i].exp_cum);
      chk("tbl_max_bin", dmb, tbl[i].exp_mb);
      chk("tbl_max_count", dmc, tbl[i].exp_mc);
      if (tbl[i].mode == 2) chk("backpressure_stall_cycles", stall, 4);
      if (tbl[i].poke) begin
        repeat (3) @(negedge clk);
        chk("poke_no_second_pass", busy, 0);
        chk("poke_no_extra_beats", q.size(), 8);
      end
    end

    // Reset while bin 4 waits in OUT.
    hist = tbl[0].b;
    ready_mode = 0;
    @(negedge clk);
    start = 1'b1;
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid && out_bin == 3'd4) found = 1;
    end
    chk("reached_bin4", found, 1);
    #1 rst = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_gate", acc_en_gate, 1);
    chk("abort_max_bin", max_bin, 0);
    chk("abort_max_count", max_count, 0);
    @(negedge clk);
    rst = 1'b1;
    run_pass(tbl[0].b, 0, 0, 1, dc, dmb, dmc);
    chk("restart_final_cum", dc, 360);

    // start held high across the end of a pass re-arms immediately.
    hist = tbl[1].b;
    q.delete();
    @(negedge clk);
    start = 1'b1;
    wait_done(seen, cyc);
    chk("held_start_done1", seen, 1);
    @(negedge clk);
    chk("held_start_idle_gap", busy, 0);
    @(negedge clk);
    chk("held_start_rearmed", busy, 1);
    chk("held_start_addr0", hist_addr, 0);
    start = 1'b0;
    wait_done(seen, cyc);
    chk("held_start_done2", seen, 1);
    @(negedge clk);
    chk("held_start_beats", q.size(), 16);
    chk("held_start_max_bin", max_bin, 1);

    // Randomized histograms under random backpressure.
    for (int p = 0; p < 6; p++) begin
      for (int k = 0; k < 8; k++) begin
        case ($urandom_range(0, 4))
          0: r[k] = 14'd0;
          1: r[k] = 14'd16383;
          2: r[k] = 14'($urandom_range(0, 3));
          default: r[k] = 14'($urandom_range(0, 16383));
        endcase
      end
      run_pass(r, 1, 0, 0, dc, dmb, dmc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
